uart_frame_decoder: RTL and testbench

Receive-side framing layer for the UART link. Consumes the byte strobe stream produced by the UART receiver (`ready` / `data_output`) and reassembles framed bus commands (sync, command, address, data, optional checksum) into one parallel word. It is the decoder for the frames the host-side encoder emits, and it feeds the bus initiator through a valid/ready handshake. The block also detects inter-byte timeout, checksum mismatch and output overrun.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_timeout.sv | 33 +++
 rtl/uart_frame_decoder.sv | 197 +++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: types and constants shared by the
// UART frame decoder and the host-side frame encoder.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    CHK
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // command byte fields
  localparam int CMD_WR_BIT = 0;

  // byte counter covers 1..4 bytes per field
  localparam int BCNT_W = 2;

endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout: inter-byte idle counter.
// Reloads to zero on clear or when disabled; pulses expire at LIMIT-1.
module uart_frame_timeout
  import uart_frame_pkg::*;
#(
  parameter int LIMIT = 52080
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  assign expire = enable & ~clear &
                  (cnt_q == W'(LIMIT - 1));

  // count idle clocks while a frame is open
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear | ~enable | expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: reassembles sync/cmd/addr/data[/chk] byte frames.
// Define UART_FRAME_CHECKSUM_EN to require and verify the trailing XOR byte.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         ADDR_BYTES     = 2,
  parameter int         DATA_BYTES     = 1,
  parameter int         TIMEOUT_CLOCKS = 52080
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [7:0]              frame_cmd,
  output logic [8*ADDR_BYTES-1:0] frame_addr,
  output logic [8*DATA_BYTES-1:0] frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    chk_err,
  output logic                    timeout_err,
  output logic                    overrun_err
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              done;
  logic              expire;
  logic              load;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
  logic       bad;
  logic       chk_q;
`endif

  uart_frame_timeout #(
    .LIMIT (TIMEOUT_CLOCKS)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (byte_valid),
    .enable (state_q != IDLE),
    .expire (expire)
  );

  // an overrun-free completion: register empty or being drained now
  assign load = done & (~frame_valid | frame_ready);

  // next state and field shifting for each received byte
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    done    = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    acc_d   = acc_q;
    bad     = 1'b0;
`endif
    if (expire) begin
      state_d = IDLE;
      bcnt_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
      acc_d   = '0;
`endif
    end else if (byte_valid) begin
      unique case (state_q)
        IDLE: begin
          if (byte_in == SYNC_BYTE) begin
            state_d = CMD;
            bcnt_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            acc_d   = '0;
`endif
          end
        end
        CMD: begin
          cmd_d   = byte_in;
          state_d = ADDR;
`ifdef UART_FRAME_CHECKSUM_EN
          acc_d   = byte_in;
`endif
        end
        ADDR: begin
          addr_d      = addr_q << 8;
          addr_d[7:0] = byte_in;
`ifdef UART_FRAME_CHECKSUM_EN
          acc_d       = acc_q ^ byte_in;
`endif
          if (bcnt_q == BCNT_W'(ADDR_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = DATA;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        DATA: begin
          data_d      = data_q << 8;
          data_d[7:0] = byte_in;
`ifdef UART_FRAME_CHECKSUM_EN
          acc_d       = acc_q ^ byte_in;
`endif
          if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) begin
            bcnt_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
            done    = 1'b1;
`endif
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        CHK: begin
          state_d = IDLE;
          if (byte_in == acc_q) begin
            done = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM and field shift registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // output register, handshake and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid <= 1'b0;
      frame_cmd   <= '0;
      frame_addr  <= '0;
      frame_data  <= '0;
      overrun_err <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        frame_valid <= 1'b1;
        frame_cmd   <= cmd_q;
        frame_addr  <= addr_q;
        frame_data  <= data_d;
      end else if (frame_valid & frame_ready) begin
        frame_valid <= 1'b0;
      end
      overrun_err <= done & frame_valid & ~frame_ready;
      timeout_err <= expire;
    end
  end

`ifdef UART_FRAME_CHECKSUM_EN
  // checksum accumulator and mismatch pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      chk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      chk_q <= bad;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed byte-stream vectors for the frame decoder.
// Expectations follow UART_FRAME_CHECKSUM_EN when it is defined.
module tb_uart_frame_decoder;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [7:0]  frame_cmd;
  logic [15:0] frame_addr;
  logic [7:0]  frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        chk_err;
  logic        timeout_err;
  logic        overrun_err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit          valid;
    bit          chk_only;
    logic [7:0]  b;
    bit          ready;
    bit          fv;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          ce;
    bit          oe;
  } vec_t;

  vec_t tbl[$];

  uart_frame_decoder #(
    .SYNC_BYTE      (8'hA5),
    .ADDR_BYTES     (2),
    .DATA_BYTES     (1),
    .TIMEOUT_CLOCKS (52080)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .chk_err     (chk_err),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input bit v, input bit co, input logic [7:0] b,
    input bit r, input bit fv, input logic [7:0] c,
    input logic [15:0] a, input logic [7:0] d,
    input bit ce, input bit oe);
    vec_t t;
    t.valid = v; t.chk_only = co; t.b = b; t.ready = r;
    t.fv = fv; t.cmd = c; t.addr = a; t.data = d;
    t.ce = ce; t.oe = oe;
    return t;
  endfunction

  function automatic logic [35:0] outs();
    return {frame_valid, frame_cmd, frame_addr, frame_data,
            chk_err, overrun_err, timeout_err};
  endfunction

  // drive one cycle from a negedge, check half a cycle after the edge
  task automatic apply(input string tag, input vec_t v);
    logic [35:0] exp;
    if (v.chk_only && !CK) return;
    byte_valid  = v.valid;
    byte_in     = v.b;
    frame_ready = v.ready;
    @(negedge clk);
    byte_valid = 1'b0;
    exp = {v.fv, v.cmd, v.addr, v.data, v.ce, v.oe, 1'b0};
    nvec++;
    if (outs() !== exp) begin
      nerr++;
      $display("FAIL %s byte=%h: got v/cmd/addr/data/ce/oe/te=%h expected %h",
               tag, v.b, outs(), exp);
    end
  endtask

  task automatic check(input string tag, input logic [35:0] exp);
    nvec++;
    if (outs() !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, outs(), exp);
    end
  endtask

  initial begin
    int n;
    rstn        = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    frame_ready = 1'b0;

    // good frame, with and without a trailing checksum
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'h00,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h01,0, 0,8'h00,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h12,0, 0,8'h00,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h34,0, 0,8'h00,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h56,0, !CK, CK ? 8'h00 : 8'h01,
                     CK ? 16'h0000 : 16'h1234, CK ? 8'h00 : 8'h56, 0,0));
    tbl.push_back(mk(1,1,8'h71,0, 1,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 0,8'h01,16'h1234,8'h56,0,0));
    // bad checksum, then a good frame
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'h01,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'h12,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'h34,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'h56,0, !CK,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,1,8'h70,0, 0,8'h01,16'h1234,8'h56,1,0));
    tbl.push_back(mk(0,0,8'h00,1, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'h02,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'hAB,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'hCD,0, 0,8'h01,16'h1234,8'h56,0,0));
    tbl.push_back(mk(1,0,8'hEF,0, !CK, CK ? 8'h01 : 8'h02,
                     CK ? 16'h1234 : 16'hABCD, CK ? 8'h56 : 8'hEF, 0,0));
    tbl.push_back(mk(1,1,8'h8B,0, 1,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 0,8'h02,16'hABCD,8'hEF,0,0));
    // junk before sync, sync value as command
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'hFF,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'h00,0, 0,8'h02,16'hABCD,8'hEF,0,0));
    tbl.push_back(mk(1,0,8'h00,0, !CK, CK ? 8'h02 : 8'hA5,
                     CK ? 16'hABCD : 16'h0000, CK ? 8'hEF : 8'h00, 0,0));
    tbl.push_back(mk(1,1,8'hA5,0, 1,8'hA5,16'h0000,8'h00,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 0,8'hA5,16'h0000,8'h00,0,0));
    // two back-to-back frames, no drain: overrun keeps the first
    tbl.push_back(mk(1,0,8'hA5,0, 0,8'hA5,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h10,0, 0,8'hA5,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h20,0, 0,8'hA5,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h30,0, 0,8'hA5,16'h0000,8'h00,0,0));
    tbl.push_back(mk(1,0,8'h40,0, !CK, CK ? 8'hA5 : 8'h10,
                     CK ? 16'h0000 : 16'h2030, CK ? 8'h00 : 8'h40, 0,0));
    tbl.push_back(mk(1,1,8'h40,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'hA5,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h11,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h22,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h33,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h44,0, 1,8'h10,16'h2030,8'h40,0,!CK));
    tbl.push_back(mk(1,1,8'h44,0, 1,8'h10,16'h2030,8'h40,0,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,8'h10,16'h2030,8'h40,0,0));
    // completion in the same cycle as the drain loads the new frame
    tbl.push_back(mk(1,0,8'hA5,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h0F,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h01,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h02,0, 1,8'h10,16'h2030,8'h40,0,0));
    tbl.push_back(mk(1,0,8'h03,!CK, 1, CK ? 8'h10 : 8'h0F,
                     CK ? 16'h2030 : 16'h0102, CK ? 8'h40 : 8'h03, 0,0));
    tbl.push_back(mk(1,1,8'h0F,1, 1,8'h0F,16'h0102,8'h03,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 0,8'h0F,16'h0102,8'h03,0,0));

    repeat (3) @(negedge clk);
    check("reset", 36'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // partial frame then silence
    apply("to_a5", mk(1,0,8'hA5,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("to_01", mk(1,0,8'h01,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("to_12", mk(1,0,8'h12,0, 0,8'h0F,16'h0102,8'h03,0,0));
    n = 0;
    while (!timeout_err && n < 60000) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (n != 52080) begin
      nerr++;
      $display("FAIL timeout_delay: got %0d clocks expected 52080", n);
    end
    @(negedge clk);
    check("timeout_width", {1'b0, 8'h0F, 16'h0102, 8'h03, 3'b000});
    apply("d_a5", mk(1,0,8'hA5,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("d_03", mk(1,0,8'h03,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("d_55", mk(1,0,8'h55,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("d_66", mk(1,0,8'h66,0, 0,8'h0F,16'h0102,8'h03,0,0));
    apply("d_77", mk(1,0,8'h77,0, !CK, CK ? 8'h0F : 8'h03,
                     CK ? 16'h0102 : 16'h5566, CK ? 8'h03 : 8'h77, 0,0));
    apply("d_chk", mk(1,1,8'h47,0, 1,8'h03,16'h5566,8'h77,0,0));
    apply("d_idle", mk(0,0,8'h00,1, 0,8'h03,16'h5566,8'h77,0,0));

    // reset in the middle of a frame
    apply("r_a5", mk(1,0,8'hA5,0, 0,8'h03,16'h5566,8'h77,0,0));
    apply("r_01", mk(1,0,8'h01,0, 0,8'h03,16'h5566,8'h77,0,0));
    rstn = 1'b0;
    #1;
    check("midframe_reset", 36'h0);
    @(negedge clk);
    rstn = 1'b1;
    apply("e_a5", mk(1,0,8'hA5,0, 0,8'h00,16'h0000,8'h00,0,0));
    apply("e_04", mk(1,0,8'h04,0, 0,8'h00,16'h0000,8'h00,0,0));
    apply("e_00", mk(1,0,8'h00,0, 0,8'h00,16'h0000,8'h00,0,0));
    apply("e_01", mk(1,0,8'h01,0, 0,8'h00,16'h0000,8'h00,0,0));
    apply("e_02", mk(1,0,8'h02,0, !CK, CK ? 8'h00 : 8'h04,
                     CK ? 16'h0000 : 16'h0001, CK ? 8'h00 : 8'h02, 0,0));
    apply("e_chk", mk(1,1,8'h07,0, 1,8'h04,16'h0001,8'h02,0,0));
    apply("e_idle", mk(0,0,8'h00,1, 0,8'h04,16'h0001,8'h02,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
